// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: prioritises NMI over level-sensitive maskable lines, handshakes
// entry with the Controller at instruction boundaries and tracks nested handlers until eret.
module interrupt_sequencer #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0080,
  parameter int unsigned VEC_STRIDE = 8,
  parameter logic [31:0] NMI_VEC    = 32'h0000_0040
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_IRQ-1:0]                              irq_i,
  input  logic                                            nmi_i,
  input  logic                                            intd_i,
  input  logic                                            instr_boundary_i,
  input  logic                                            int_ack_i,
  input  logic                                            eret_i,
  output logic                                            int_req_o,
  output logic [31:0]                                     vector_o,
  output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1):0]  cause_o,
  output logic                                            ina_o,
  output logic                                            in_service_o
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACK     = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  function automatic logic [31:0] f_irq_vector(input logic [IDX_W-1:0] idx);
    return VEC_BASE + (32'(idx) * VEC_STRIDE);
  endfunction

  state_t           r_state;
  logic             r_nmi_prev;
  logic             r_nmi_pending;
  logic             r_nmi_active;
  logic             r_irq_active;
  logic [IDX_W-1:0] r_act_idx;
  logic             r_req_nmi;
  logic [IDX_W-1:0] r_req_idx;

  state_t           w_state_nxt;
  logic             w_nmi_pending_nxt;
  logic             w_nmi_active_nxt;
  logic             w_irq_active_nxt;
  logic [IDX_W-1:0] w_act_idx_nxt;
  logic             w_req_nmi_nxt;
  logic [IDX_W-1:0] w_req_idx_nxt;
  logic [31:0]      w_vector_nxt;
  logic             w_int_req_nxt;
  logic             w_ina_nxt;
  logic             w_in_service_nxt;
  logic [IDX_W:0]   w_cause_nxt;

  logic             w_nmi_edge;
  logic             w_nmi_cand;
  logic             w_irq_cand;
  logic             w_cand;
  logic [IDX_W-1:0] w_irq_idx;
  logic             w_req_line;
  logic             w_cancel;

  assign w_nmi_edge = nmi_i & ~r_nmi_prev;
  assign w_nmi_cand = r_nmi_pending & ~r_nmi_active;
  assign w_irq_cand = (|irq_i) & ~intd_i & ~r_irq_active & ~r_nmi_active;
  assign w_cand     = w_nmi_cand | w_irq_cand;
  assign w_req_line = irq_i[r_req_idx];
  // Only a maskable request can be withdrawn; an NMI request stays up until acknowledged.
  assign w_cancel   = ~r_req_nmi & (~w_req_line | intd_i);

  // Lowest-numbered asserted line has the highest priority.
  always_comb begin
    w_irq_idx = {IDX_W{1'b0}};
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      w_irq_idx = irq_i[i] ? IDX_W'(i) : w_irq_idx;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_nmi_prev    <= 1'b0;
      r_nmi_pending <= 1'b0;
      r_nmi_active  <= 1'b0;
      r_irq_active  <= 1'b0;
      r_act_idx     <= {IDX_W{1'b0}};
      r_req_nmi     <= 1'b0;
      r_req_idx     <= {IDX_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_nmi_prev    <= nmi_i;
      r_nmi_pending <= w_nmi_pending_nxt;
      r_nmi_active  <= w_nmi_active_nxt;
      r_irq_active  <= w_irq_active_nxt;
      r_act_idx     <= w_act_idx_nxt;
      r_req_nmi     <= w_req_nmi_nxt;
      r_req_idx     <= w_req_idx_nxt;
    end
  end

  // Next-state and bookkeeping update.
  always_comb begin
    w_state_nxt       = r_state;
    w_req_nmi_nxt     = r_req_nmi;
    w_req_idx_nxt     = r_req_idx;
    w_vector_nxt      = vector_o;
    w_nmi_active_nxt  = r_nmi_active;
    w_irq_active_nxt  = r_irq_active;
    w_act_idx_nxt     = r_act_idx;
    w_nmi_pending_nxt = r_nmi_pending | w_nmi_edge;
    case (r_state)
      S_IDLE: begin
        if (w_cand && instr_boundary_i) begin
          w_state_nxt   = S_REQ;
          w_req_nmi_nxt = w_nmi_cand;
          w_req_idx_nxt = w_nmi_cand ? {IDX_W{1'b0}} : w_irq_idx;
          w_vector_nxt  = w_nmi_cand ? NMI_VEC : f_irq_vector(w_irq_idx);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (int_ack_i) begin
          w_state_nxt = S_ACK;
        end else if (w_cancel) begin
          w_state_nxt = (r_nmi_active | r_irq_active) ? S_SERVICE : S_IDLE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_ACK: begin
        w_state_nxt = S_SERVICE;
        if (r_req_nmi) begin
          w_nmi_active_nxt  = 1'b1;
          // An edge arriving in this very cycle is a fresh request and must survive.
          w_nmi_pending_nxt = w_nmi_edge;
        end else begin
          w_irq_active_nxt = 1'b1;
          w_act_idx_nxt    = r_req_idx;
        end
      end
      S_SERVICE: begin
        if (eret_i) begin
          if (r_nmi_active) begin
            w_nmi_active_nxt = 1'b0;
          end else begin
            w_irq_active_nxt = 1'b0;
          end
          w_state_nxt = (r_nmi_active & r_irq_active) ? S_SERVICE : S_IDLE;
        end else if (w_nmi_cand && instr_boundary_i) begin
          w_state_nxt   = S_REQ;
          w_req_nmi_nxt = 1'b1;
          w_req_idx_nxt = {IDX_W{1'b0}};
          w_vector_nxt  = NMI_VEC;
        end else begin
          w_state_nxt = S_SERVICE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    w_int_req_nxt    = (w_state_nxt == S_REQ);
    w_ina_nxt        = (w_state_nxt == S_ACK);
    w_in_service_nxt = w_nmi_active_nxt | w_irq_active_nxt;
    case (w_state_nxt)
      S_REQ, S_ACK: begin
        w_cause_nxt = {w_req_nmi_nxt, w_req_idx_nxt};
      end
      S_SERVICE: begin
        if (w_nmi_active_nxt) begin
          w_cause_nxt = {1'b1, {IDX_W{1'b0}}};
        end else begin
          w_cause_nxt = {1'b0, w_act_idx_nxt};
        end
      end
      default: begin
        w_cause_nxt = {(IDX_W + 1){1'b0}};
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_req_o    <= 1'b0;
      vector_o     <= 32'h0000_0000;
      cause_o      <= {(IDX_W + 1){1'b0}};
      ina_o        <= 1'b0;
      in_service_o <= 1'b0;
    end else begin
      int_req_o    <= w_int_req_nxt;
      vector_o     <= w_vector_nxt;
      cause_o      <= w_cause_nxt;
      ina_o        <= w_ina_nxt;
      in_service_o <= w_in_service_nxt;
    end
  end

endmodule
